mc_control: RTL
===============

# mc_control

Multi-cycle MIPS main control unit: the next-generation control block for the datapath, replacing single-cycle decode with a Moore FSM. It sequences fetch/decode/execute/memory/writeback over several cycles with a req/ready memory handshake, a bounded wait timer, and a trap state for illegal opcodes and bus timeouts. It sits between the instruction register (opcode/funct), the ALU zero flag, the shared memory port, and the datapath mux/enable controls.

## Interface
- MAX_WAIT, 15: maximum consecutive stalled cycles (mem_req=1 & mem_ready=0) before bus error; legal range 1..255.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req, mem_we, iord  out  1 each  memory request, write, address select (0 PC, 1 ALUOut).
- ir_write, pc_write, reg_write  out  1 each  register enables.
- pc_src  out  2  0 ALU, 1 ALUOut, 2 jump target, 3 register A.
- reg_dst  out  2  0 rt, 1 rd, 2 $31.
- mem_to_reg  out  2  0 ALUOut, 1 MDR, 2 PC.
- alu_src_a  out  1  0 PC, 1 A. alu_src_b out 2: 0 B, 1 const 4, 2 sext imm, 3 sext imm<<2.
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded.
- state_o  out  4  current state encoding.
- illegal, bus_err  out  1 each  sticky trap causes.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, ALU_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP, JAL, JR, TRAP. Outputs are decoded from state; unlisted outputs are 0.
- FETCH: mem_req, a=0, b=1, op=00, pc_src=0; ir_write=pc_write=mem_ready. Advance to DECODE when mem_ready.
- DECODE: a=0, b=3, op=00. Next: lw(0x23)/sw(0x2B)->MEM_ADDR; opcode 0 with funct 0x08->JR, other opcode 0->EXEC; addi(0x08)->ADDI_EXEC; beq(0x04)/bne(0x05)->BRANCH; j(0x02)->JUMP; jal(0x03)->JAL; anything else->TRAP, illegal<=1.
- MEM_ADDR: a=1, b=2, op=00; ->MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req, iord=1; ->MEM_WB on mem_ready. MEM_WB: reg_write, reg_dst=0, mem_to_reg=1; ->FETCH.
- MEM_WR: mem_req, mem_we, iord=1; ->FETCH on mem_ready.
- EXEC: a=1, b=0, op=10; ->ALU_WB: reg_write, reg_dst=1, mem_to_reg=0; ->FETCH.
- ADDI_EXEC: a=1, b=2, op=00; ->ADDI_WB: reg_write, reg_dst=0, mem_to_reg=0; ->FETCH.
- BRANCH: a=1, b=0, op=01, pc_src=1; pc_write = (beq & zero) | (bne & ~zero); ->FETCH.
- JUMP: pc_src=2, pc_write. JAL: JUMP outputs plus reg_write, reg_dst=2, mem_to_reg=2. JR: pc_src=3, pc_write. All ->FETCH.
- Wait timer: counts cycles with mem_req & ~mem_ready, cleared on mem_ready or leaving a memory state. Reaching MAX_WAIT -> TRAP, bus_err<=1, mem_req drops next cycle.
- TRAP: all enables 0; held until reset. illegal/bus_err only clear on reset.

## Timing
- Reset (async): state FETCH, timer 0, illegal=bus_err=0. Outputs during/after reset = FETCH decode: mem_req=1, alu_src_b=1, rest 0; ir_write/pc_write forced 0 while rst_n=0.
- Zero-wait latency: lw 5, sw/R/addi 4, beq/bne/j/jal/jr 3 cycles.
- Each stalled memory cycle adds 1; outputs held stable while waiting.
- Timeout: stall cycle MAX_WAIT is the last in the memory state; TRAP entered on the next edge.
- mem_ready outside a memory state is ignored.

## Configuration
- MC_CTRL_LINK_EN defined: jal and jr decoded as above.
- Undefined: JAL/JR states not built; jal opcode and funct 0x08 route to TRAP with illegal=1.

## Structure
- Package mc_ctrl_pkg: state enum (4-bit), opcode/funct constants, pc_src/reg_dst/mem_to_reg/alu_op/alu_src_b encodings.
- Sub-module mc_wait_timer: parametrised stall counter with clear and timeout output.

## Test plan
- Reset mid-MEM_RD -> state_o=FETCH, mem_req=1, illegal=bus_err=0 immediately.
- lw, mem_ready always 1 -> FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; reg_write with mem_to_reg=1 in cycle 5.
- beq zero=1 -> pc_write=1, pc_src=1 in BRANCH; bne zero=1 -> pc_write=0.
- sw with mem_ready low 3 cycles in MEM_WR -> 3 extra cycles, mem_we held, then FETCH.
- FETCH mem_ready low 15 cycles (MAX_WAIT=15) -> TRAP, bus_err=1, mem_req=0 thereafter.
- opcode 0x3F -> TRAP, illegal=1; jal with MC_CTRL_LINK_EN -> reg_dst=2, mem_to_reg=2, pc_write=1; without -> TRAP.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: state enum,
// opcode/funct constants and datapath mux select codes.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_RD    = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WR    = 4'd5,
      S_EXEC      = 4'd6,
      S_ALU_WB    = 4'd7,
      S_ADDI_EXEC = 4'd8,
      S_ADDI_WB   = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11,
      S_JAL       = 4'd12,
      S_JR        = 4'd13,
      S_TRAP      = 4'd14
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;

   localparam logic [1:0] PCS_ALU    = 2'd0;
   localparam logic [1:0] PCS_ALUOUT = 2'd1;
   localparam logic [1:0] PCS_JUMP   = 2'd2;
   localparam logic [1:0] PCS_REGA   = 2'd3;

   localparam logic [1:0] RDST_RT = 2'd0;
   localparam logic [1:0] RDST_RD = 2'd1;
   localparam logic [1:0] RDST_RA = 2'd2;

   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   // States that hold the shared memory port and may stall on mem_ready.
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Consecutive-stall counter; o_timeout flags the stall cycle that reaches MAX_WAIT.
module mc_wait_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_stall,
   output logic o_timeout
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] r_cnt;

   // r_cnt holds the number of earlier stall cycles, so the current one is r_cnt+1.
   assign o_timeout = i_stall && (r_cnt == CNT_W'(MAX_WAIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_stall && (r_cnt != CNT_W'(MAX_WAIT))) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS main control FSM with memory handshake, stall timeout and trap.
// Define MC_CTRL_LINK_EN to build the jal/jr states; otherwise they decode as illegal.
module mc_control
   import mc_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] pc_src,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [3:0] state_o,
   output logic       illegal,
   output logic       bus_err
);

   state_t r_state;
   logic   r_illegal;
   logic   r_bus_err;
   logic   w_stall;
   logic   w_timeout;

   assign w_stall = is_mem_state(r_state) && !mem_ready;

   mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (!w_stall),
      .i_stall   (w_stall),
      .o_timeout (w_timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
         r_bus_err <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
               if (mem_ready) begin
                  case (r_state)
                     S_FETCH:  r_state <= S_DECODE;
                     S_MEM_RD: r_state <= S_MEM_WB;
                     default:  r_state <= S_FETCH;
                  endcase
               end else if (w_timeout) begin
                  r_state   <= S_TRAP;
                  r_bus_err <= 1'b1;
               end
            end
            S_DECODE: begin
               case (opcode)
                  OP_LW, OP_SW: r_state <= S_MEM_ADDR;
                  OP_RTYPE: begin
                     if (funct == FN_JR) begin
`ifdef MC_CTRL_LINK_EN
                        r_state   <= S_JR;
`else
                        r_state   <= S_TRAP;
                        r_illegal <= 1'b1;
`endif
                     end else begin
                        r_state <= S_EXEC;
                     end
                  end
                  OP_ADDI:        r_state <= S_ADDI_EXEC;
                  OP_BEQ, OP_BNE: r_state <= S_BRANCH;
                  OP_J:           r_state <= S_JUMP;
`ifdef MC_CTRL_LINK_EN
                  OP_JAL:         r_state <= S_JAL;
`endif
                  default: begin
                     r_state   <= S_TRAP;
                     r_illegal <= 1'b1;
                  end
               endcase
            end
            S_MEM_ADDR:  r_state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_EXEC:      r_state <= S_ALU_WB;
            S_ADDI_EXEC: r_state <= S_ADDI_WB;
            S_TRAP:      r_state <= S_TRAP;
            default:     r_state <= S_FETCH;
         endcase
      end
   end

   // Moore decode of the registered state; only the FETCH enables and the
   // branch pc_write look at live inputs.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      pc_src     = PCS_ALU;
      reg_dst    = RDST_RT;
      mem_to_reg = M2R_ALUOUT;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_op     = ALUOP_ADD;
      case (r_state)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready && rst_n;
            pc_write  = mem_ready && rst_n;
         end
         S_DECODE:   alu_src_b = SRCB_IMM_SH;
         S_MEM_ADDR, S_ADDI_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = M2R_MDR;
         end
         S_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            reg_dst   = RDST_RD;
         end
         S_ADDI_WB:  reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_SUB;
            pc_src    = PCS_ALUOUT;
            pc_write  = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
         end
         S_JUMP: begin
            pc_src   = PCS_JUMP;
            pc_write = 1'b1;
         end
`ifdef MC_CTRL_LINK_EN
         S_JAL: begin
            pc_src     = PCS_JUMP;
            pc_write   = 1'b1;
            reg_write  = 1'b1;
            reg_dst    = RDST_RA;
            mem_to_reg = M2R_PC;
         end
         S_JR: begin
            pc_src   = PCS_REGA;
            pc_write = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign state_o = r_state;
   assign illegal = r_illegal;
   assign bus_err = r_bus_err;

endmodule
